mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single external memory port between the CPU (port 0) and the DMA/video engine (port 1).
- Holds a registered grant for one requester at a time and muxes that requester's address, data and strobes onto the memory bus.
- Returns the memory ready/read data to the granted requester only.
- Sits between the CPU top level, the DMA engine and the memory/IO decoder. Uses round-robin arbitration with back-to-back switching.

Parameters:
- M, 16, data bus width
- N, 32, address bus width
- TIMEOUT, 64, cycles a granted transaction may wait for memReady (optional feature only)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- cpuAddr  in  N  CPU address
- cpuWrite  in  M  CPU write data
- cpuRE  in  1  CPU read request
- cpuWE  in  1  CPU write request
- cpuRead  out  M  read data to CPU
- cpuReady  out  1  CPU transaction complete
- dmaAddr  in  N  DMA address
- dmaWrite  in  M  DMA write data
- dmaRE  in  1  DMA read request
- dmaWE  in  1  DMA write request
- dmaRead  out  M  read data to DMA
- dmaReady  out  1  DMA transaction complete
- memAddr  out  N  memory address
- memWrite  out  M  memory write data
- memRE  out  1  memory read enable
- memWE  out  1  memory write enable
- memReadIn  in  M  memory read data
- memReady  in  1  memory ready
- grant  out  2  debug: 00 idle, 01 CPU, 10 DMA
- busErr  out  1  one-cycle pulse on timeout abort

Behaviour:
- Request per port: reqX = reXX | weXX.
  - Requester holds address, data and strobes stable until its ready pulse.
  - If a port asserts RE and WE together, it is a write: memRE forced 0.
- FSM (registered) states: IDLE, GNT_CPU, GNT_DMA. lastGrant is a 1-bit register.
- Reset (async):
  - state IDLE, lastGrant = DMA (so CPU wins the first tie).
  - Counter 0.
  - All outputs 0: mem*, *Ready, *Read, grant, busErr.
- IDLE:
  - Outputs: memRE = memWE = 0, memAddr = 0, memWrite = 0.
  - Only one request: grant it next cycle.
  - Both requesting: grant the port that is not lastGrant.
  - Arbitration latency is 1 cycle: the request seen in cycle t is on the bus in cycle t+1.
- GNT_x:
  - memAddr/memWrite/memRE/memWE combinationally follow port x.
  - xReady = memReady & reqx, combinational (same cycle as memReady).
  - xRead = memReadIn. The other port's Ready and Read are 0.
- Completion (memReady & reqx):
  - lastGrant <= x.
  - Other port requesting: go directly to GNT_other (no idle cycle).
  - Else if reqx is still high (new transaction): stay in GNT_x.
  - Else: IDLE.
- Abort: reqx drops before memReady → IDLE next cycle, no ready pulse, lastGrant unchanged.
- Fairness: under continuous requests from both ports, grants alternate strictly, one transaction each.
- memReady while IDLE is ignored.
- Reset mid-transaction: immediate return to IDLE, strobes deassert asynchronously.
- grant output = encoded state.

Optional Feature:
- Macro MEM_BUS_ARBITER_TIMEOUT_EN.
- When defined:
  - An 8-bit wait counter clears on entering GNT_x and increments each granted cycle without memReady.
  - When the counter reaches TIMEOUT-1 without memReady, that cycle pulses xReady = 1 and busErr = 1, with xRead = all ones.
  - The grant then releases per the completion rules and the counter clears.
- When undefined: no counter, waits indefinitely, busErr tied 0.

Decomposition:
- Shared package/constants file:
  - grant/state encodings: ARB_IDLE = 2'b00, ARB_CPU = 2'b01, ARB_DMA = 2'b10.
  - Port index constants.
- Sub-module rr_pick2: 2-input round-robin picker (req0, req1, lastGrant → pick0, pick1, valid), purely combinational.
- FSM, muxing and timeout stay in the top module.

Test Plan:
- Reset with both ports idle → grant = 00, mem* = 0, both Ready = 0. Then CPU read of 0x00001234 with memReady = 1 → memAddr = 0x00001234 next cycle, cpuReady the same cycle memReady is seen, cpuRead = memReadIn = 0xBEEF.
- CPU and DMA request in the same cycle after reset → CPU granted first. On completion the grant switches directly to DMA with no idle cycle (grant 01 → 10).
- Both ports request continuously, memReady = 1 every cycle → grant alternates 01, 10, 01, 10; each port's Ready pulses every other cycle.
- DMA write 0xA5A5 to 0xD0000010 with memReady held low for 5 cycles → memWE = 1 and memWrite = 0xA5A5 held stable for 6 cycles. dmaReady pulses once and cpuReady stays 0 throughout.
- CPU drops cpuRE mid-wait → IDLE next cycle, no cpuReady. Pending DMA is granted after that. Separately, assert rst mid-transaction → memRE = memWE = 0 immediately.
- With MEM_BUS_ARBITER_TIMEOUT_EN and TIMEOUT = 4, CPU read with memReady stuck at 0 → on the 4th granted cycle cpuReady = 1, busErr = 1, cpuRead = 0xFFFF, then grant releases.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: grant/state encodings and port indices shared by the arbiter files.
package mem_bus_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_CPU  = 2'b01,
    ARB_DMA  = 2'b10
  } arb_state_t;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-input round-robin picker; on a tie the port that did not win last time is chosen.
module rr_pick2
  import mem_bus_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic pick0,
  output logic pick1,
  output logic valid
);
  assign pick0 = req0 & (~req1 | (last_grant == PORT_DMA));
  assign pick1 = req1 & (~req0 | (last_grant == PORT_CPU));
  assign valid = req0 | req1;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin CPU/DMA arbiter for the single memory port.
// Optional wait timeout with busErr pulse enabled by MEM_BUS_ARBITER_TIMEOUT_EN.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int M       = 16,
  parameter int N       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] cpuAddr,
  input  logic [M-1:0] cpuWrite,
  input  logic         cpuRE,
  input  logic         cpuWE,
  output logic [M-1:0] cpuRead,
  output logic         cpuReady,
  input  logic [N-1:0] dmaAddr,
  input  logic [M-1:0] dmaWrite,
  input  logic         dmaRE,
  input  logic         dmaWE,
  output logic [M-1:0] dmaRead,
  output logic         dmaReady,
  output logic [N-1:0] memAddr,
  output logic [M-1:0] memWrite,
  output logic         memRE,
  output logic         memWE,
  input  logic [M-1:0] memReadIn,
  input  logic         memReady,
  output logic [1:0]   grant,
  output logic         busErr
);
  arb_state_t state;
  logic last_grant, req_c, req_d, gc, gd, cur_req, other_req, to, done;
  logic pick0, pick1, valid;
  assign req_c     = cpuRE | cpuWE;
  assign req_d     = dmaRE | dmaWE;
  assign gc        = state == ARB_CPU;
  assign gd        = state == ARB_DMA;
  assign cur_req   = (gc & req_c) | (gd & req_d);
  assign other_req = (gc & req_d) | (gd & req_c);
  assign done      = cur_req & (memReady | to);
  rr_pick2 u_pick (
    .req0      (req_c),
    .req1      (req_d),
    .last_grant(last_grant),
    .pick0     (pick0),
    .pick1     (pick1),
    .valid     (valid)
  );
  // A simultaneous RE+WE is treated as a write, so RE is masked by WE.
  assign memAddr  = gc ? cpuAddr : gd ? dmaAddr : '0;
  assign memWrite = gc ? cpuWrite : gd ? dmaWrite : '0;
  assign memWE    = (gc & cpuWE) | (gd & dmaWE);
  assign memRE    = (gc & cpuRE & ~cpuWE) | (gd & dmaRE & ~dmaWE);
  assign cpuReady = gc & done;
  assign dmaReady = gd & done;
  assign cpuRead  = ~gc ? '0 : to ? '1 : memReadIn;
  assign dmaRead  = ~gd ? '0 : to ? '1 : memReadIn;
  assign busErr   = to;
  assign grant    = state;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  logic [7:0] cnt;
  assign to = cur_req & ~memReady & (cnt == 8'(TIMEOUT - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (~cur_req | done) ? '0 : cnt + 8'd1;
`else
  // Timeout disabled: the comparison is constant false and only keeps TIMEOUT referenced.
  assign to = TIMEOUT < 0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= ARB_IDLE;
      last_grant <= PORT_DMA;
    end else if (state == ARB_IDLE) begin
      state <= ~valid ? ARB_IDLE : pick0 ? ARB_CPU : ARB_DMA;
    end else if (~cur_req) begin
      state <= ARB_IDLE;
    end else if (done) begin
      last_grant <= gd ? PORT_DMA : PORT_CPU;
      state      <= ~other_req ? state : gc ? ARB_DMA : ARB_CPU;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed stimulus with an abstract arbitration model checked every cycle.
module tb_mem_bus_arbiter;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  localparam bit TE = 1'b1;
`else
  localparam bit TE = 1'b0;
`endif
  localparam int TIMEOUT = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] cpuAddr = '0, dmaAddr = '0, memAddr;
  logic [15:0] cpuWrite = '0, dmaWrite = '0, cpuRead, dmaRead, memWrite, memReadIn = '0;
  logic cpuRE = 0, cpuWE = 0, dmaRE = 0, dmaWE = 0, memReady = 0;
  logic cpuReady, dmaReady, memRE, memWE, busErr;
  logic [1:0] grant;
  int passed = 0, total = 0;
  mem_bus_arbiter #(.M(16), .N(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cpuAddr(cpuAddr), .cpuWrite(cpuWrite), .cpuRE(cpuRE), .cpuWE(cpuWE),
    .cpuRead(cpuRead), .cpuReady(cpuReady),
    .dmaAddr(dmaAddr), .dmaWrite(dmaWrite), .dmaRE(dmaRE), .dmaWE(dmaWE),
    .dmaRead(dmaRead), .dmaReady(dmaReady),
    .memAddr(memAddr), .memWrite(memWrite), .memRE(memRE), .memWE(memWE),
    .memReadIn(memReadIn), .memReady(memReady), .grant(grant), .busErr(busErr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // Model: owner is 0 idle, 1 CPU, 2 DMA; last is the port index of the last completed owner.
  int owner = 0, last = 1, waited = 0;
  logic p_req, o_req, e_to, e_rdy, e_re, e_we;
  logic [31:0] e_addr;
  logic [15:0] e_wd, e_rd;
  always_comb begin
    p_req = 0; o_req = 0; e_to = 0; e_rdy = 0; e_re = 0; e_we = 0;
    e_addr = '0; e_wd = '0; e_rd = '0;
    if (owner != 0) begin
      p_req  = owner == 1 ? (cpuRE | cpuWE) : (dmaRE | dmaWE);
      o_req  = owner == 1 ? (dmaRE | dmaWE) : (cpuRE | cpuWE);
      e_we   = owner == 1 ? cpuWE : dmaWE;
      e_re   = (owner == 1 ? cpuRE : dmaRE) && !e_we;
      e_addr = owner == 1 ? cpuAddr : dmaAddr;
      e_wd   = owner == 1 ? cpuWrite : dmaWrite;
      e_to   = TE && p_req && !memReady && waited == TIMEOUT - 1;
      e_rdy  = p_req && (memReady || e_to);
      e_rd   = e_to ? 16'hFFFF : memReadIn;
    end
  end
  always @(posedge clk or posedge rst)
    if (rst) begin
      owner <= 0; last <= 1; waited <= 0;
    end else if (owner == 0) begin
      waited <= 0;
      if ((cpuRE | cpuWE) && (dmaRE | dmaWE)) owner <= last == 1 ? 1 : 2;
      else if (cpuRE | cpuWE) owner <= 1;
      else if (dmaRE | dmaWE) owner <= 2;
    end else if (!p_req) begin
      owner <= 0; waited <= 0;
    end else if (e_rdy) begin
      last <= owner - 1; waited <= 0;
      if (o_req) owner <= 3 - owner;
    end else waited <= waited + 1;
  always @(negedge clk)
    if (!rst) begin
      chk("grant", 32'(grant), 32'(owner));
      chk("memAddr", memAddr, e_addr);
      chk("memWrite", 32'(memWrite), 32'(e_wd));
      chk("memRE", 32'(memRE), 32'(e_re));
      chk("memWE", 32'(memWE), 32'(e_we));
      chk("cpuReady", 32'(cpuReady), 32'(owner == 1 && e_rdy));
      chk("dmaReady", 32'(dmaReady), 32'(owner == 2 && e_rdy));
      chk("cpuRead", 32'(cpuRead), owner == 1 ? 32'(e_rd) : 32'd0);
      chk("dmaRead", 32'(dmaRead), owner == 2 ? 32'(e_rd) : 32'd0);
      chk("busErr", 32'(busErr), 32'(e_to));
    end
  logic [1:0] alt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_mem", {memRE, memWE, cpuReady, dmaReady, busErr}, 32'h0);
    rst = 0;
    step;
    cpuAddr = 32'h0000_1234; cpuRE = 1; memReady = 1; memReadIn = 16'hBEEF;
    @(negedge clk);
    chk("t1_wait_addr", memAddr, 32'h0);
    step;
    @(negedge clk);
    chk("t1_addr", memAddr, 32'h0000_1234);
    chk("t1_ready", 32'(cpuReady), 32'h1);
    chk("t1_read", 32'(cpuRead), 32'hBEEF);
    step;
    cpuRE = 0; memReady = 0;
    repeat (2) step;
    rst = 1;
    step;
    rst = 0;
    step;
    cpuRE = 1; dmaRE = 1; dmaAddr = 32'h0000_0040; memReady = 1;
    @(negedge clk);
    chk("t2_idle", 32'(grant), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step;
      @(negedge clk);
      chk("t3_alt_grant", 32'(grant), 32'(alt[i]));
      chk("t3_cpu_ready", 32'(cpuReady), 32'(i % 2 == 0));
      chk("t3_dma_ready", 32'(dmaReady), 32'(i % 2 == 1));
    end
    step;
    cpuRE = 0; dmaRE = 0; memReady = 0;
    repeat (2) step;
    dmaWE = 1; dmaAddr = 32'hD000_0010; dmaWrite = 16'hA5A5;
    for (int i = 0; i < 6; i++) begin
      step;
      memReady = i == 5;
      @(negedge clk);
`ifndef MEM_BUS_ARBITER_TIMEOUT_EN
      chk("t4_we", 32'(memWE), 32'h1);
      chk("t4_data", 32'(memWrite), 32'hA5A5);
      chk("t4_dma_ready", 32'(dmaReady), 32'(i == 5));
      chk("t4_cpu_ready", 32'(cpuReady), 32'h0);
`endif
    end
    step;
    dmaWE = 0; memReady = 0;
    repeat (2) step;
    cpuRE = 1; cpuAddr = 32'h0000_2000;
    step;
    dmaRE = 1; dmaAddr = 32'h0000_3000;
    @(negedge clk);
    chk("t5_cpu_grant", 32'(grant), 32'h1);
    step;
    cpuRE = 0;
    @(negedge clk);
    chk("t5_no_ready", 32'(cpuReady), 32'h0);
    step;
    @(negedge clk);
    chk("t5_abort_idle", 32'(grant), 32'h0);
    step;
    memReady = 1;
    @(negedge clk);
    chk("t5_dma_grant", 32'(grant), 32'h2);
    chk("t5_dma_ready", 32'(dmaReady), 32'h1);
    step;
    dmaRE = 0; memReady = 0;
    repeat (2) step;
    cpuWE = 1; cpuWrite = 16'h1111;
    step;
    @(negedge clk);
    chk("t6_we_before", 32'(memWE), 32'h1);
    #2 rst = 1;
    #1;
    chk("t6_rst_strobes", {memRE, memWE}, 32'h0);
    chk("t6_rst_grant", 32'(grant), 32'h0);
    step;
    rst = 0; cpuWE = 0;
    repeat (2) step;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    cpuRE = 1; cpuAddr = 32'h0000_4000;
    for (int i = 0; i < 4; i++) begin
      step;
      @(negedge clk);
      chk("to_ready", 32'(cpuReady), 32'(i == 3));
      chk("to_buserr", 32'(busErr), 32'(i == 3));
      if (i == 3) chk("to_read", 32'(cpuRead), 32'hFFFF);
    end
    step;
    cpuRE = 0;
    step;
    @(negedge clk);
    chk("to_release", 32'(grant), 32'h0);
`endif
    step;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
